elevator_motion_ctrl: RTL and testbench
=======================================

Name: elevator_motion_ctrl

Overview:
- Car motion scheduler for the 2-way, 7-floor elevator.
- Latches hall and cab requests and picks the travel direction with a SCAN (collective) policy.
- Steps the car one floor per travel interval and stops at serviceable floors.
- Sequences the door through an open-request/closed handshake; drives current_floor, current_direction, current_floor_button and the moving signal used to hold the door controller in reset.

Parameters:
- CLK_PER_FLOOR, 100000000, clock cycles to travel one floor (>=2)
- DOOR_TIMEOUT, 1000000000, cycles waiting for door_open to rise before aborting the stop (>=2)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- hall_up  input  [7:1]  up-call buttons, level; bit 7 ignored
- hall_down  input  [7:1]  down-call buttons, level; bit 1 ignored
- cab_req  input  [7:1]  internal floor buttons, level
- door_open  input  1  door state from door controller, 1=open
- current_floor  output  3  floor 1..7, binary
- current_direction  output  2  00 STOP, 01 UP, 10 DOWN
- current_floor_button  output  2  {pend_down[f], pend_up[f]} at current floor
- moving  output  1  high in MOVE; feeds door controller reset
- door_open_req  output  1  one-cycle pulse requesting door open
- pend_up, pend_down, pend_cab  output  [7:1]  latched request registers

Behaviour:
- Reset: current_floor=1, direction=STOP, moving=0, door_open_req=0, all pend=0, state=IDLE, counter=0.
- Latching: pend_x[i] set every cycle its input bit is high; set has priority over clear except for the floor being serviced in STOP or DOOR states.
- Service set S(f,dir) = pend_cab[f] | (dir==UP ? pend_up[f] : pend_down[f]).
- above = any pend at floors > f; below = any pend at floors < f.
- IDLE:
  - Pend at the current floor -> STOP, direction chosen by that floor's hall bit (up preferred).
  - Else above -> direction UP, MOVE.
  - Else below -> direction DOWN, MOVE.
  - Else stay, direction STOP.
- MOVE:
  - moving=1; counter loads CLK_PER_FLOOR-1 on entry and decrements.
  - At 0: floor += 1 (UP) or -= 1 (DOWN).
  - At the new floor, evaluate the following in the same cycle:
    - If S(new,dir), or nothing pending beyond in dir, -> STOP.
    - Else reload the counter and continue.
  - Floor 7 while UP and floor 1 while DOWN always stop; the floor never wraps.
- STOP (1 cycle):
  - moving=0; door_open_req=1.
  - Clear pend_cab[f] and the hall bit for dir.
  - If nothing pending beyond in dir, reverse dir to the remaining hall bit at f, clear it too, and set direction STOP if no pend remain anywhere.
  - -> DOOR_OPEN.
- DOOR_OPEN:
  - Wait for door_open=1, then -> DOOR_CLOSE.
  - Timeout counter reaching DOOR_TIMEOUT -> IDLE; the request stays cleared.
- DOOR_CLOSE:
  - Wait for door_open=0, then -> IDLE (re-evaluate).
  - Presses at the current floor matching dir are cleared immediately while in DOOR_OPEN/DOOR_CLOSE; the door controller reopens on them.
- Simultaneous above and below requests with direction STOP: UP wins.
- Reset mid-MOVE: the car position register returns to 1. The system must reset only at floor 1 or while homed; this is documented, not detected.
- door_open asserted during MOVE is ignored (interlock is the door's reset via moving).

Optional Feature:
- EMERGENCY_STOP_EN: adds input estop (1 bit, level).
- With estop high:
  - MOVE finishes the current floor and then enters STOP without clearing requests.
  - All pend registers are cleared and held 0.
  - Direction is forced to STOP and the car stays in IDLE until estop is low.
- Without the macro, the port is absent and no estop logic exists.

Test Plan:
- CLK_PER_FLOOR=4, reset, cab_req[4] pulse -> moving for 12 cycles, floor 1->2->3->4, door_open_req pulse at floor 4, pend_cab=0.
- At floor 1: hall_down[5] and cab_req[3] -> stop at 3 (cab), continue UP, stop at 5, direction reverses to DOWN then STOP, pend all 0.
- Car at 4 moving UP toward 6, hall_down[5] pressed -> no stop at 5; after 6 serviced, reverse and stop at 5.
- Idle at 3, hall_up[3] -> no movement, door_open_req pulse, current_floor_button=2'b01 before clear, then 00.
- DOOR_OPEN with door_open held 0 for DOOR_TIMEOUT=8 cycles -> return to IDLE on cycle 8; with door_open 1 then 0 -> IDLE one cycle after the fall.
- EMERGENCY_STOP_EN: estop mid-travel 2->3 -> arrive at 3, direction=00, pend cleared, new cab_req ignored until estop low.

Source files
------------

// File: rtl/elevator_motion_ctrl_if.sv
// rtl/elevator_motion_ctrl_if.sv - request, door handshake and status bundle of the car motion scheduler
//
// Purpose: groups the hall/cab request inputs, the door handshake and the
// car status outputs so the scheduler and its environment share one port.
//
// Signals:
//   hall_up[7:1]         up-call buttons, level (bit 7 has no meaning)
//   hall_down[7:1]       down-call buttons, level (bit 1 has no meaning)
//   cab_req[7:1]         in-car floor buttons, level
//   door_open            door state from the door controller, 1 = open
//   current_floor        floor 1..7, binary
//   current_direction    00 STOP, 01 UP, 10 DOWN
//   current_floor_button {pend_down[f], pend_up[f]} at the current floor
//   moving               high while travelling; holds the door controller in reset
//   door_open_req        one-cycle door open request
//   pend_up/down/cab     latched request registers
//
// Modports: master = scheduler side, slave = car / door environment side.
interface elevator_motion_ctrl_if;
  logic [7:1] hall_up;
  logic [7:1] hall_down;
  logic [7:1] cab_req;
  logic       door_open;
  logic [2:0] current_floor;
  logic [1:0] current_direction;
  logic [1:0] current_floor_button;
  logic       moving;
  logic       door_open_req;
  logic [7:1] pend_up;
  logic [7:1] pend_down;
  logic [7:1] pend_cab;

  modport master (
    input  hall_up, hall_down, cab_req, door_open,
    output current_floor, current_direction, current_floor_button,
           moving, door_open_req, pend_up, pend_down, pend_cab
  );

  modport slave (
    output hall_up, hall_down, cab_req, door_open,
    input  current_floor, current_direction, current_floor_button,
           moving, door_open_req, pend_up, pend_down, pend_cab
  );
endinterface

// File: rtl/elevator_motion_ctrl.sv
// rtl/elevator_motion_ctrl.sv - SCAN (collective) motion scheduler for the 2-way 7-floor elevator
//
// Purpose: latches hall and cab calls, picks the travel direction, steps the
// car one floor per CLK_PER_FLOOR cycles, stops at serviceable floors and
// sequences the door through the open-request / open / closed handshake.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   estop  emergency stop, level (only with EMERGENCY_STOP_EN defined)
//   car    elevator_motion_ctrl_if.master: requests, door handshake, status
//
// Parameters:
//   CLK_PER_FLOOR  cycles to travel one floor (>= 2)
//   DOOR_TIMEOUT   cycles to wait for door_open before abandoning the stop (>= 2)
//
// Optional build macro: EMERGENCY_STOP_EN adds the estop input. With estop
// high the car finishes the floor it is travelling to, all requests are
// cleared and held clear, and direction is forced to STOP.
//
// Reset returns the position register to floor 1 regardless of where the car
// is; the system is only to be reset at floor 1 or while homed.
module elevator_motion_ctrl #(
  parameter int unsigned CLK_PER_FLOOR = 100000000,
  parameter int unsigned DOOR_TIMEOUT  = 1000000000
) (
  input  logic clk,
  input  logic reset,
`ifdef EMERGENCY_STOP_EN
  input  logic estop,
`endif
  elevator_motion_ctrl_if.master car
);

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE,
    ST_STOP,
    ST_DOOR_OPEN,
    ST_DOOR_CLOSE
  } state_t;

  state_t      r_state;
  logic [2:0]  r_floor;
  logic [1:0]  r_dir;
  logic [31:0] r_cnt;
  logic        r_moving;
  logic        r_door_req;
  logic [7:1]  r_pend_up;
  logic [7:1]  r_pend_down;
  logic [7:1]  r_pend_cab;

  logic        w_estop;
  logic [7:1]  w_in_up;
  logic [7:1]  w_in_down;
  logic [7:1]  w_any;
  logic [7:1]  w_fmask;
  logic [7:1]  w_nmask;
  logic [2:0]  w_next_floor;
  logic        w_above;
  logic        w_below;
  logic        w_cur_beyond;
  logic        w_next_beyond;
  logic        w_next_serve;
  logic        w_here_up;
  logic        w_here_down;
  logic        w_here_any;
  logic [7:1]  w_clr_up;
  logic [7:1]  w_clr_down;
  logic [7:1]  w_clr_cab;
  logic [7:1]  w_pend_up_nxt;
  logic [7:1]  w_pend_down_nxt;
  logic [7:1]  w_pend_cab_nxt;

`ifdef EMERGENCY_STOP_EN
  assign w_estop = estop;
`else
  assign w_estop = 1'b0;
`endif

  function automatic logic [7:1] floor_mask(input logic [2:0] f);
    logic [7:1] m;
    for (int i = 1; i <= 7; i++) m[i] = (3'(i) == f);
    return m;
  endfunction

  // Any request strictly beyond floor f in direction d; STOP has no "beyond".
  function automatic logic pend_beyond(input logic [7:1] any, input logic [2:0] f,
                                       input logic [1:0] d);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      if ((d == DIR_UP && 3'(i) > f) || (d == DIR_DOWN && 3'(i) < f))
        hit = hit | any[i];
    end
    return hit;
  endfunction

  // No up call exists above floor 7 and no down call below floor 1.
  assign w_in_up   = car.hall_up   & 7'b0111111;
  assign w_in_down = car.hall_down & 7'b1111110;

  assign w_any   = r_pend_up | r_pend_down | r_pend_cab;
  assign w_fmask = floor_mask(r_floor);

  // The floor never wraps: travel is clamped at 1 and 7.
  always_comb begin
    w_next_floor = r_floor;
    if (r_dir == DIR_UP && r_floor != 3'd7)
      w_next_floor = r_floor + 3'd1;
    else if (r_dir == DIR_DOWN && r_floor != 3'd1)
      w_next_floor = r_floor - 3'd1;
  end

  assign w_nmask       = floor_mask(w_next_floor);
  assign w_above       = pend_beyond(w_any, r_floor, DIR_UP);
  assign w_below       = pend_beyond(w_any, r_floor, DIR_DOWN);
  assign w_cur_beyond  = pend_beyond(w_any, r_floor, r_dir);
  assign w_next_beyond = pend_beyond(w_any, w_next_floor, r_dir);
  assign w_next_serve  = |(w_nmask & r_pend_cab) |
                         ((r_dir == DIR_UP) ? |(w_nmask & r_pend_up) : |(w_nmask & r_pend_down));
  assign w_here_up     = |(w_fmask & r_pend_up);
  assign w_here_down   = |(w_fmask & r_pend_down);
  assign w_here_any    = |(w_fmask & w_any);

  // Clears only ever target the current floor, and only while stopped there;
  // at that floor the clear beats a held button so the door controller
  // (not the scheduler) handles re-presses.
  always_comb begin
    w_clr_up   = '0;
    w_clr_down = '0;
    w_clr_cab  = '0;
    if (r_state == ST_STOP) begin
      w_clr_cab = w_fmask;
      if (w_cur_beyond) begin
        if (r_dir == DIR_UP) w_clr_up   = w_fmask;
        else                 w_clr_down = w_fmask;
      end else begin
        // Turning around (or parking): the opposite hall call is answered too.
        w_clr_up   = w_fmask;
        w_clr_down = w_fmask;
      end
    end else if (r_state == ST_DOOR_OPEN || r_state == ST_DOOR_CLOSE) begin
      w_clr_cab = w_fmask;
      if (r_dir != DIR_DOWN) w_clr_up   = w_fmask;
      if (r_dir != DIR_UP)   w_clr_down = w_fmask;
    end
  end

  always_comb begin
    w_pend_up_nxt   = (r_pend_up   | w_in_up)     & ~w_clr_up;
    w_pend_down_nxt = (r_pend_down | w_in_down)   & ~w_clr_down;
    w_pend_cab_nxt  = (r_pend_cab  | car.cab_req) & ~w_clr_cab;
    if (w_estop) begin
      w_pend_up_nxt   = '0;
      w_pend_down_nxt = '0;
      w_pend_cab_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_floor     <= 3'd1;
      r_dir       <= DIR_STOP;
      r_cnt       <= '0;
      r_moving    <= 1'b0;
      r_door_req  <= 1'b0;
      r_pend_up   <= '0;
      r_pend_down <= '0;
      r_pend_cab  <= '0;
    end else begin
      r_pend_up   <= w_pend_up_nxt;
      r_pend_down <= w_pend_down_nxt;
      r_pend_cab  <= w_pend_cab_nxt;
      r_door_req  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_moving <= 1'b0;
          if (w_estop) begin
            r_dir <= DIR_STOP;
          end else if (w_here_any) begin
            r_state    <= ST_STOP;
            r_door_req <= 1'b1;
            // A cab-only stop keeps a downward sweep going down.
            if (w_here_up)
              r_dir <= DIR_UP;
            else if (w_here_down || r_dir == DIR_DOWN)
              r_dir <= DIR_DOWN;
            else
              r_dir <= DIR_UP;
          end else if ((r_dir == DIR_DOWN && w_below) || w_above || w_below) begin
            // Keep sweeping down if already going down; otherwise UP wins.
            r_dir    <= ((r_dir == DIR_DOWN && w_below) || !w_above) ? DIR_DOWN : DIR_UP;
            r_state  <= ST_MOVE;
            r_moving <= 1'b1;
            r_cnt    <= 32'(CLK_PER_FLOOR - 1);
          end else begin
            r_dir <= DIR_STOP;
          end
        end

        ST_MOVE: begin
          if (r_cnt == '0) begin
            r_floor <= w_next_floor;
            if (w_estop || w_next_serve || !w_next_beyond) begin
              r_state    <= ST_STOP;
              r_moving   <= 1'b0;
              r_door_req <= 1'b1;
            end else begin
              r_cnt <= 32'(CLK_PER_FLOOR - 1);
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end

        ST_STOP: begin
          r_state <= ST_DOOR_OPEN;
          r_cnt   <= '0;
          if (w_estop) begin
            r_dir <= DIR_STOP;
          end else if (!w_cur_beyond) begin
            // Nothing ahead: anything still pending lies behind, so reverse.
            if (r_dir == DIR_UP)
              r_dir <= w_below ? DIR_DOWN : DIR_STOP;
            else if (r_dir == DIR_DOWN)
              r_dir <= w_above ? DIR_UP : DIR_STOP;
            else
              r_dir <= DIR_STOP;
          end
        end

        ST_DOOR_OPEN: begin
          if (w_estop) r_dir <= DIR_STOP;
          if (car.door_open)
            r_state <= ST_DOOR_CLOSE;
          else if (r_cnt == 32'(DOOR_TIMEOUT - 1))
            r_state <= ST_IDLE;
          else
            r_cnt <= r_cnt + 32'd1;
        end

        ST_DOOR_CLOSE: begin
          if (w_estop) r_dir <= DIR_STOP;
          if (!car.door_open) r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign car.current_floor        = r_floor;
  assign car.current_direction    = r_dir;
  assign car.current_floor_button = {w_here_down, w_here_up};
  assign car.moving               = r_moving;
  assign car.door_open_req        = r_door_req;
  assign car.pend_up              = r_pend_up;
  assign car.pend_down            = r_pend_down;
  assign car.pend_cab             = r_pend_cab;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// tb/tb_elevator_motion_ctrl.sv - directed self-checking bench for elevator_motion_ctrl
//
// Purpose: drives hall/cab calls and the door handshake with directed
// vectors (CLK_PER_FLOOR=4, DOOR_TIMEOUT=8) and compares status outputs
// against hand-computed values. Estop scenario only with EMERGENCY_STOP_EN.
module tb_elevator_motion_ctrl;

  logic clk;
  logic reset;
`ifdef EMERGENCY_STOP_EN
  logic estop;
`endif

  int n_tests;
  int n_fail;

  elevator_motion_ctrl_if car ();

  elevator_motion_ctrl #(
    .CLK_PER_FLOOR(4),
    .DOOR_TIMEOUT (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
`ifdef EMERGENCY_STOP_EN
    .estop(estop),
`endif
    .car  (car)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    car.hall_up    = '0;
    car.hall_down  = '0;
    car.cab_req    = '0;
    car.door_open  = 1'b0;
`ifdef EMERGENCY_STOP_EN
    estop          = 1'b0;
`endif
    tick(2);
    reset = 1'b0;
  endtask

  task automatic press(input logic [7:1] up, input logic [7:1] dn, input logic [7:1] cab);
    car.hall_up   = up;
    car.hall_down = dn;
    car.cab_req   = cab;
    tick(1);
    car.hall_up   = '0;
    car.hall_down = '0;
    car.cab_req   = '0;
  endtask

  task automatic wait_door_req(input string tag);
    int n;
    n = 0;
    while (car.door_open_req !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    check(tag, 32'(car.door_open_req), 32'd1);
  endtask

  task automatic wait_floor(input logic [2:0] f, input string tag);
    int n;
    n = 0;
    while (car.current_floor !== f && n < 300) begin
      tick(1);
      n++;
    end
    check(tag, 32'(car.current_floor), 32'(f));
  endtask

  // Door controller stand-in: open for two cycles, then close.
  task automatic serve_door();
    car.door_open = 1'b1;
    tick(2);
    car.door_open = 1'b0;
    tick(2);
  endtask

  initial begin
    int mv;
    int n;
    n_tests = 0;
    n_fail  = 0;

    // Reset state and single cab trip 1 -> 4.
    do_reset();
    check("rst_floor", 32'(car.current_floor), 32'd1);
    check("rst_dir", 32'(car.current_direction), 32'd0);
    check("rst_moving", 32'(car.moving), 32'd0);
    check("rst_door_req", 32'(car.door_open_req), 32'd0);
    check("rst_pend", 32'({car.pend_up, car.pend_down, car.pend_cab}), 32'd0);

    press('0, '0, 7'b0001000);
    check("t1_latched", 32'(car.pend_cab), 32'b0001000);
    mv = 0;
    n  = 0;
    while (car.moving !== 1'b1 && n < 50) begin tick(1); n++; end
    while (car.moving === 1'b1 && n < 100) begin mv++; tick(1); n++; end
    check("t1_move_cycles", 32'(mv), 32'd12);
    check("t1_door_req", 32'(car.door_open_req), 32'd1);
    check("t1_floor", 32'(car.current_floor), 32'd4);
    tick(1);
    check("t1_req_pulse", 32'(car.door_open_req), 32'd0);
    check("t1_pend_cab", 32'(car.pend_cab), 32'd0);
    check("t1_dir", 32'(car.current_direction), 32'd0);
    serve_door();

    // Cab 3 then hall-down 5 from floor 1.
    do_reset();
    press('0, 7'b0010000, 7'b0000100);
    wait_door_req("t2_stop3");
    check("t2_floor3", 32'(car.current_floor), 32'd3);
    check("t2_dir_up", 32'(car.current_direction), 32'd1);
    tick(1);
    check("t2_cab_clr", 32'(car.pend_cab), 32'd0);
    check("t2_down5_kept", 32'(car.pend_down), 32'b0010000);
    check("t2_still_up", 32'(car.current_direction), 32'd1);
    serve_door();
    wait_door_req("t2_stop5");
    check("t2_floor5", 32'(car.current_floor), 32'd5);
    tick(1);
    check("t2_dir_stop", 32'(car.current_direction), 32'd0);
    check("t2_pend_all", 32'({car.pend_up, car.pend_down, car.pend_cab}), 32'd0);
    serve_door();

    // Passing a down call on the way up, then serving it on the way back.
    do_reset();
    press('0, '0, 7'b0100000);
    wait_floor(3'd4, "t3_at4");
    press('0, 7'b0010000, '0);
    wait_door_req("t3_stop6");
    check("t3_floor6", 32'(car.current_floor), 32'd6);
    tick(1);
    check("t3_reverse", 32'(car.current_direction), 32'd2);
    check("t3_down5", 32'(car.pend_down), 32'b0010000);
    serve_door();
    wait_door_req("t3_stop5");
    check("t3_floor5", 32'(car.current_floor), 32'd5);
    tick(1);
    check("t3_dir_stop", 32'(car.current_direction), 32'd0);
    check("t3_down_clr", 32'(car.pend_down), 32'd0);
    serve_door();

    // Idle at 3, hall-up at 3: no travel, door request, button clears.
    do_reset();
    press('0, '0, 7'b0000100);
    wait_door_req("t4_reach3");
    serve_door();
    tick(3);
    press(7'b0000100, '0, '0);
    check("t4_btn_set", 32'(car.current_floor_button), 32'd1);
    tick(1);
    check("t4_req", 32'(car.door_open_req), 32'd1);
    check("t4_not_moving", 32'(car.moving), 32'd0);
    check("t4_btn_before", 32'(car.current_floor_button), 32'd1);
    check("t4_dir_up", 32'(car.current_direction), 32'd1);
    tick(1);
    check("t4_btn_clr", 32'(car.current_floor_button), 32'd0);
    check("t4_req_pulse", 32'(car.door_open_req), 32'd0);
    check("t4_dir_stop", 32'(car.current_direction), 32'd0);
    check("t4_floor", 32'(car.current_floor), 32'd3);

    // Door never opens: DOOR_OPEN times out after 8 cycles, then travel to 5.
    press('0, '0, 7'b0010000);
    tick(7);
    check("t5_before_to", 32'(car.moving), 32'd0);
    tick(1);
    check("t5_after_to", 32'(car.moving), 32'd1);
    check("t5_dir", 32'(car.current_direction), 32'd1);

    // Door opens then closes: back to IDLE one cycle after the fall.
    wait_door_req("t6_stop5");
    check("t6_floor5", 32'(car.current_floor), 32'd5);
    tick(1);
    car.door_open = 1'b1;
    car.cab_req   = 7'b0000010;
    tick(1);
    car.cab_req   = '0;
    tick(1);
    car.door_open = 1'b0;
    tick(1);
    check("t6_idle_hold", 32'(car.moving), 32'd0);
    tick(1);
    check("t6_move", 32'(car.moving), 32'd1);
    check("t6_dir_down", 32'(car.current_direction), 32'd2);
    wait_door_req("t6_stop2");
    check("t6_floor2", 32'(car.current_floor), 32'd2);
    serve_door();

    // Ignored hall bits and the top-floor boundary.
    press(7'b1000000, 7'b0000001, 7'b1000000);
    check("t7_up7_ign", 32'(car.pend_up), 32'd0);
    check("t7_dn1_ign", 32'(car.pend_down), 32'd0);
    check("t7_cab7", 32'(car.pend_cab), 32'b1000000);
    wait_door_req("t7_stop7");
    check("t7_floor7", 32'(car.current_floor), 32'd7);
    tick(1);
    check("t7_dir", 32'(car.current_direction), 32'd0);
    serve_door();
    tick(4);
    check("t7_no_wrap", 32'(car.current_floor), 32'd7);
    check("t7_parked", 32'(car.moving), 32'd0);

`ifdef EMERGENCY_STOP_EN
    do_reset();
    press('0, '0, 7'b0010000);
    wait_floor(3'd2, "es_at2");
    estop = 1'b1;
    wait_door_req("es_stop");
    check("es_floor3", 32'(car.current_floor), 32'd3);
    tick(1);
    check("es_dir", 32'(car.current_direction), 32'd0);
    check("es_pend", 32'({car.pend_up, car.pend_down, car.pend_cab}), 32'd0);
    car.cab_req = 7'b0100000;
    serve_door();
    tick(4);
    check("es_hold_floor", 32'(car.current_floor), 32'd3);
    check("es_hold_move", 32'(car.moving), 32'd0);
    check("es_hold_pend", 32'(car.pend_cab), 32'd0);
    car.cab_req = '0;
    estop = 1'b0;
    press('0, '0, 7'b0100000);
    wait_door_req("es_resume");
    check("es_floor6", 32'(car.current_floor), 32'd6);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
